// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: steps stim through 0..2^N_IN-1 (HOLD_CYCLES clocks each), checks dut_out against EXP_TABLE.
// Latency: sweep takes 2^N_IN*HOLD_CYCLES cycles from the first APPLY cycle; start is ignored while busy.
// Optional macro SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch with stim frozen on the failing vector.
module truth_table_sweeper #(
  parameter int N_IN        = 3,
  parameter int N_OUT       = 2,
  parameter int HOLD_CYCLES = 10,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXP_TABLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_OUT-1:0]  dut_out,
  output logic [N_IN-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [N_IN-1:0] stim_d;
  logic            busy_d;
  logic            done_d;
  logic            pass_d;
  logic [N_IN:0]   err_d;
  logic            fail_valid_d;
  logic [N_IN-1:0] first_fail_d;

  logic [N_OUT-1:0] exp_vec;
  logic             mismatch;
  logic             finish;

  assign exp_vec = EXP_TABLE[int'(stim) * N_OUT +: N_OUT];

  // Case inequality so that X/Z on the DUT outputs is scored as a failure.
  assign mismatch = (dut_out !== exp_vec);

  always_comb begin
    state_d      = state;
    hold_d       = hold_cnt;
    stim_d       = stim;
    busy_d       = busy;
    done_d       = done;
    pass_d       = pass;
    err_d        = err_count;
    fail_valid_d = fail_valid;
    first_fail_d = first_fail_vec;
    finish       = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d      = APPLY;
          hold_d       = HOLD_RELOAD;
          stim_d       = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
        end
      end

      APPLY: begin
        if (hold_cnt != '0) begin
          hold_d = hold_cnt - HW'(1);
        end else begin
          if (mismatch) begin
            err_d = err_count + (N_IN+1)'(1);
            if (!fail_valid) begin
              fail_valid_d = 1'b1;
              first_fail_d = stim;
            end
          end
`ifdef SWEEP_STOP_ON_FAIL_EN
          finish = mismatch || (stim == LAST_VEC);
`else
          finish = (stim == LAST_VEC);
`endif
          if (finish) begin
            // stim is left on the last compared vector for visibility on the board.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            stim_d = stim + N_IN'(1);
            hold_d = HOLD_RELOAD;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      state          <= state_d;
      hold_cnt       <= hold_d;
      stim           <= stim_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      fail_valid     <= fail_valid_d;
      first_fail_vec <= first_fail_d;
    end
  end

endmodule
